// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer family.
package timer_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_nbit.sv
// Loadable n-bit down-counter with start/pause/abort and a one-cycle done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from the stored period at terminal count and stay in RUN.
module countdown_timer_nbit
  import timer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_valid,
  input  logic [CNT_WIDTH-1:0] load_value,
  output logic                 load_ready,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 abort,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 busy,
  output logic                 done
);

  state_t               state;
  logic [CNT_WIDTH-1:0] reload;
  logic                 at_terminal;

  assign at_terminal = (count <= CNT_WIDTH'(1));
  assign busy        = (state == RUN);
  assign load_ready  = (state != RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        count <= '0;
      end else if (load_valid && (state != RUN)) begin
        count  <= load_value;
        reload <= load_value;
        state  <= ARMED;
      end else begin
        case (state)
          ARMED: begin
            // count always equals reload while ARMED, so this leaves count unchanged
            if (start) begin
              state <= RUN;
              count <= reload;
            end
          end
          RUN: begin
            if (!pause) begin
              if (at_terminal) begin
                done <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                count <= reload;
`else
                count <= '0;
                state <= IDLE;
`endif
              end else begin
                count <= count - CNT_WIDTH'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer_nbit.sv
// Scoreboard bench for countdown_timer_nbit: directed steps push expected outputs, a monitor compares.
module tb_countdown_timer_nbit;

  logic       clk;
  logic       reset_n;
  logic       load_valid;
  logic [7:0] load_value;
  logic       load_ready;
  logic       start;
  logic       pause;
  logic       abort;
  logic [7:0] count;
  logic       busy;
  logic       done;

  typedef struct {
    string      name;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       rdy;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  countdown_timer_nbit #(.CNT_WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_obs(input exp_t e);
    tests++;
    if (count !== e.cnt || busy !== e.busy || done !== e.done || load_ready !== e.rdy) begin
      fails++;
      $display("FAIL %s: got count=%0d busy=%0b done=%0b load_ready=%0b, expected count=%0d busy=%0b done=%0b load_ready=%0b",
               e.name, count, busy, done, load_ready, e.cnt, e.busy, e.done, e.rdy);
    end
  endtask

  // Monitor: one expected observation per clock edge, sampled 2 time units after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_obs(e);
      end
    end
  end

  task automatic step(input string name, input logic lv, input logic [7:0] val,
                      input logic st, input logic pa, input logic ab,
                      input logic [7:0] ec, input logic eb, input logic ed, input logic er);
    exp_t e;
    load_valid = lv;
    load_value = val;
    start      = st;
    pause      = pa;
    abort      = ab;
    e.name = name;
    e.cnt  = ec;
    e.busy = eb;
    e.done = ed;
    e.rdy  = er;
    sb.push_back(e);
    @(posedge clk);
    #3;
    load_valid = 1'b0;
    start      = 1'b0;
    pause      = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic idle(input string name, input logic [7:0] ec, input logic eb,
                      input logic ed, input logic er);
    step(name, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, ec, eb, ed, er);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_value = 8'd0;
    start      = 1'b0;
    pause      = 1'b0;
    abort      = 1'b0;
    r.name = "reset_values";
    r.cnt  = 8'd0;
    r.busy = 1'b0;
    r.done = 1'b0;
    r.rdy  = 1'b1;
    #12;
    check_obs(r);
    #1 reset_n = 1'b1;

    // Asynchronous reset in the middle of a run
    step("rst_load8",  1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 8'd8, 1'b0, 1'b0, 1'b1);
    step("rst_start",  1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd8, 1'b1, 1'b0, 1'b0);
    idle("rst_run7", 8'd7, 1'b1, 1'b0, 1'b0);
    idle("rst_run6", 8'd6, 1'b1, 1'b0, 1'b0);
    idle("rst_run5", 8'd5, 1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    r.name = "async_reset_midrun";
    check_obs(r);
    reset_n = 1'b1;

    // Load and start together in ARMED: the load wins
    step("ls_load3",     1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);
    step("ls_load9_st",  1'b1, 8'd9, 1'b1, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0, 1'b1);
    idle("ls_still_armed", 8'd9, 1'b0, 1'b0, 1'b1);
    step("ls_start",     1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0);
    step("ls_abort",     1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);

    // Abort with start in ARMED, then start in IDLE is ignored
    step("as_load2",     1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1);
    step("as_abort_st",  1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    step("idle_start",   1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);

    // Abort at count=2
    step("ab_load5",  1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b1);
    step("ab_start",  1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0);
    idle("ab_run4", 8'd4, 1'b1, 1'b0, 1'b0);
    idle("ab_run3", 8'd3, 1'b1, 1'b0, 1'b0);
    idle("ab_run2", 8'd2, 1'b1, 1'b0, 1'b0);
    step("ab_abort",  1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    idle("ab_no_done", 8'd0, 1'b0, 1'b0, 1'b1);

    // Abort in the terminal cycle suppresses done
    step("at_load2",  1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1);
    step("at_start",  1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
    idle("at_run1", 8'd1, 1'b1, 1'b0, 1'b0);
    step("at_abort",  1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    idle("at_no_done", 8'd0, 1'b0, 1'b0, 1'b1);

    // Pause has no effect in ARMED
    step("pa_load3",  1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);
    step("pa_start_paused", 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    step("pa_abort",  1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // One-shot of 4
    step("os_load4",  1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b1);
    step("os_start",  1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
    idle("os_run3", 8'd3, 1'b1, 1'b0, 1'b0);
    idle("os_run2", 8'd2, 1'b1, 1'b0, 1'b0);
    idle("os_run1", 8'd1, 1'b1, 1'b0, 1'b0);
    idle("os_done", 8'd0, 1'b0, 1'b1, 1'b1);
    idle("os_after", 8'd0, 1'b0, 1'b0, 1'b1);

    // Pause three cycles at count=3 delays done by three cycles
    step("ps_load6",  1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 8'd6, 1'b0, 1'b0, 1'b1);
    step("ps_start",  1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b0);
    idle("ps_run5", 8'd5, 1'b1, 1'b0, 1'b0);
    idle("ps_run4", 8'd4, 1'b1, 1'b0, 1'b0);
    idle("ps_run3", 8'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("ps_hold3", 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    idle("ps_run2", 8'd2, 1'b1, 1'b0, 1'b0);
    idle("ps_run1", 8'd1, 1'b1, 1'b0, 1'b0);
    idle("ps_done", 8'd0, 1'b0, 1'b1, 1'b1);
    idle("ps_after", 8'd0, 1'b0, 1'b0, 1'b1);

    // Zero period: done one edge after start
    step("z_load0",  1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    step("z_start",  1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    idle("z_done", 8'd0, 1'b0, 1'b1, 1'b1);
    idle("z_after", 8'd0, 1'b0, 1'b0, 1'b1);

    // Maximum period, with a load attempt while busy
    step("max_load255", 1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 8'd255, 1'b0, 1'b0, 1'b1);
    step("max_start",   1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 255; k++)
      step((k == 10) ? "max_load_ignored" : "max_run", (k == 10), 8'd7, 1'b0, 1'b0, 1'b0,
           8'(255 - k), 1'b1, 1'b0, 1'b0);
    idle("max_done", 8'd0, 1'b0, 1'b1, 1'b1);
    idle("max_after", 8'd0, 1'b0, 1'b0, 1'b1);
`else
    // Auto-reload of 3: done every third edge, busy held
    step("ar_load3",  1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);
    step("ar_start",  1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 12; e++)
      step("ar_period", (e == 5), 8'd9, 1'b0, 1'b0, 1'b0,
           (e % 3 == 0) ? 8'd3 : 8'(3 - (e % 3)), 1'b1, (e % 3 == 0), 1'b0);
    step("ar_abort",  1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      idle("ar_no_done", 8'd0, 1'b0, 1'b0, 1'b1);

    // Auto-reload of 0: done every cycle
    step("ar0_load0", 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    step("ar0_start", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      idle("ar0_done", 8'd0, 1'b1, 1'b1, 1'b0);
    step("ar0_abort", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
`endif

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
